// File: rtl/lzw_backward_dictionary_walk_pkg.sv
// Shared constants, field widths and FSM encoding for the LZW backward dictionary walk.
package lzw_backward_dictionary_walk_pkg;

    localparam int unsigned ClearCode = 256;
    localparam int unsigned EndCode   = 257;
    localparam int unsigned FirstFree = 258;
    localparam int unsigned SuffixW   = 8;
    localparam int unsigned LenW      = 5;

    typedef enum logic [1:0] {
        StIdle,
        StWalk,
        StUpdate
    } state_e;

    // Dictionary entry layout is {prefix, suffix, len}.
    function automatic int unsigned entry_width(input int unsigned code_w);
        return code_w + SuffixW + LenW;
    endfunction

endpackage

// File: rtl/lzw_backward_dictionary_walk_if.sv
// Code input handshake plus reversed-byte output bus of the dictionary walk stage.
interface lzw_backward_dictionary_walk_if #(
    parameter int unsigned CODE_W = 12
);
    logic [CODE_W-1:0] code;
    logic              code_en;
    logic              code_rdy;
    logic              out_afull;
    logic [7:0]        dictionary_recv_data;
    logic              dictionary_recv_data_en;
    logic              reverse_byte_flag;
    logic [4:0]        reverse_byte_num;
    logic              reverse_byte_num_wren;
    logic              err_code;
    logic [15:0]       code_cnt;
    logic [15:0]       byte_cnt;
    logic [15:0]       err_cnt;

    modport master (
        output code, code_en, out_afull,
        input  code_rdy, dictionary_recv_data, dictionary_recv_data_en, reverse_byte_flag,
        input  reverse_byte_num, reverse_byte_num_wren, err_code, code_cnt, byte_cnt, err_cnt
    );

    modport slave (
        input  code, code_en, out_afull,
        output code_rdy, dictionary_recv_data, dictionary_recv_data_en, reverse_byte_flag,
        output reverse_byte_num, reverse_byte_num_wren, err_code, code_cnt, byte_cnt, err_cnt
    );
endinterface

// File: rtl/lzw_backward_dictionary_walk_dict_ram.sv
// Simple dual-port dictionary RAM: one write port, one synchronous read port.
module lzw_backward_dictionary_walk_dict_ram #(
    parameter int unsigned AddrW = 12,
    parameter int unsigned DataW = 25
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [DataW-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [DataW-1:0] rdata
);

    logic [DataW-1:0] mem [2**AddrW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lzw_backward_dictionary_walk.sv
// LZW decode dictionary: walks each code's prefix chain and emits the string last byte first.
module lzw_backward_dictionary_walk
    import lzw_backward_dictionary_walk_pkg::*;
#(
    parameter int unsigned CODE_W  = 12,
    parameter int unsigned MAX_LEN = 31
) (
    input logic                           I_sys_clk,
    input logic                           I_sys_rst_n,
    input logic                           I_state_clr,
    lzw_backward_dictionary_walk_if.slave bus
);

    localparam int unsigned EntryW = entry_width(CODE_W);
    localparam int unsigned NcW    = CODE_W + 1;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   cur_q, cur_d, code_q, code_d, prev_code_q, prev_code_d;
    logic [NcW-1:0]      next_code_q, next_code_d;
    logic                prev_valid_q, prev_valid_d, kwk_q, kwk_d, first_q, first_d;
    logic [LenW-1:0]     prev_len_q, prev_len_d, len_q, len_d;
    logic [7:0]          prev_first_q, prev_first_d, first_char_q, first_char_d;

    logic [7:0]          data_q;
    logic                data_en_q, flag_q, err_q;
    logic [LenW-1:0]     num_q;
    logic [15:0]         code_cnt_q, byte_cnt_q, err_cnt_q;

    logic [EntryW-1:0]   rd_entry, wr_entry;
    logic [CODE_W-1:0]   rd_prefix;
    logic [7:0]          rd_suffix;
    logic [LenW-1:0]     rd_len, str_len;
    logic [NcW-1:0]      code_ext;
    logic                code_lit, is_clear, is_end, is_kwk, is_bad, cur_lit;
    logic                accept, err, emit, wr_en;
    logic [7:0]          emit_byte;

    assign rd_prefix = rd_entry[EntryW-1 -: CODE_W];
    assign rd_suffix = rd_entry[LenW +: SuffixW];
    assign rd_len    = rd_entry[LenW-1:0];
    assign wr_entry  = {prev_code_q, first_char_q, prev_len_q + LenW'(1)};

    assign code_ext = {1'b0, bus.code};
    assign code_lit = bus.code < CODE_W'(ClearCode);
    assign is_clear = bus.code == CODE_W'(ClearCode);
    assign is_end   = bus.code == CODE_W'(EndCode);
    assign is_kwk   = prev_valid_q && (code_ext == next_code_q);
    assign is_bad   = !code_lit && !is_clear && !is_end && (!prev_valid_q || code_ext > next_code_q);
    assign cur_lit  = cur_q < CODE_W'(ClearCode);
    assign str_len  = kwk_q ? prev_len_q + LenW'(1) : (cur_lit ? LenW'(1) : rd_len);

    // Read address follows cur_d so a prefix is fetched the same cycle it is decoded.
    lzw_backward_dictionary_walk_dict_ram #(
        .AddrW(CODE_W),
        .DataW(EntryW)
    ) u_dict_ram (
        .clk  (I_sys_clk),
        .we   (wr_en),
        .waddr(next_code_q[CODE_W-1:0]),
        .wdata(wr_entry),
        .raddr(cur_d),
        .rdata(rd_entry)
    );

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            code_q       <= '0;
            prev_code_q  <= '0;
            next_code_q  <= NcW'(FirstFree);
            prev_valid_q <= 1'b0;
            kwk_q        <= 1'b0;
            first_q      <= 1'b0;
            prev_len_q   <= '0;
            len_q        <= '0;
            prev_first_q <= '0;
            first_char_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            code_q       <= code_d;
            prev_code_q  <= prev_code_d;
            next_code_q  <= next_code_d;
            prev_valid_q <= prev_valid_d;
            kwk_q        <= kwk_d;
            first_q      <= first_d;
            prev_len_q   <= prev_len_d;
            len_q        <= len_d;
            prev_first_q <= prev_first_d;
            first_char_q <= first_char_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        code_d       = code_q;
        prev_code_d  = prev_code_q;
        next_code_d  = next_code_q;
        prev_valid_d = prev_valid_q;
        kwk_d        = kwk_q;
        first_d      = first_q;
        prev_len_d   = prev_len_q;
        len_d        = len_q;
        prev_first_d = prev_first_q;
        first_char_d = first_char_q;
        case (state_q)
            StIdle: begin
                if (bus.code_en) begin
                    if (is_clear) begin
                        next_code_d  = NcW'(FirstFree);
                        prev_valid_d = 1'b0;
                    end else if (is_end) begin
                        prev_valid_d = 1'b0;
                    end else if (!is_bad) begin
                        state_d = StWalk;
                        code_d  = bus.code;
                        // KwKwK walks the previous string after leading with its first char.
                        cur_d   = is_kwk ? prev_code_q : bus.code;
                        kwk_d   = is_kwk;
                        first_d = 1'b1;
                    end
                end
            end
            StWalk: begin
                if (emit) begin
                    first_d = 1'b0;
                    if (first_q) begin
                        len_d = str_len;
                    end
                    if (kwk_q) begin
                        kwk_d = 1'b0;
                    end else if (cur_lit) begin
                        first_char_d = cur_q[7:0];
                        state_d      = StUpdate;
                    end else begin
                        cur_d = rd_prefix;
                    end
                end
            end
            StUpdate: begin
                if (wr_en) begin
                    next_code_d = next_code_q + NcW'(1);
                end
                prev_code_d  = code_q;
                prev_len_d   = len_q;
                prev_first_d = first_char_q;
                prev_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        err       = 1'b0;
        emit      = 1'b0;
        emit_byte = '0;
        wr_en     = 1'b0;
        case (state_q)
            StIdle: begin
                accept = bus.code_en;
                err    = bus.code_en && is_bad;
            end
            StWalk: begin
                emit = !bus.out_afull;
                if (kwk_q) begin
                    emit_byte = prev_first_q;
                end else if (cur_lit) begin
                    emit_byte = cur_q[7:0];
                end else begin
                    emit_byte = rd_suffix;
                end
            end
            StUpdate: begin
                wr_en = prev_valid_q && (prev_len_q < LenW'(MAX_LEN)) && !next_code_q[CODE_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            data_q     <= '0;
            data_en_q  <= 1'b0;
            flag_q     <= 1'b0;
            num_q      <= '0;
            err_q      <= 1'b0;
            code_cnt_q <= '0;
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            data_q    <= emit_byte;
            data_en_q <= emit;
            flag_q    <= emit && first_q;
            err_q     <= err;
            if (emit && first_q) begin
                num_q <= str_len;
            end
            if (I_state_clr) begin
                code_cnt_q <= '0;
                byte_cnt_q <= '0;
                err_cnt_q  <= '0;
            end else begin
                if (accept) code_cnt_q <= code_cnt_q + 16'd1;
                if (emit)   byte_cnt_q <= byte_cnt_q + 16'd1;
                if (err)    err_cnt_q  <= err_cnt_q + 16'd1;
            end
        end
    end

    assign bus.code_rdy                = state_q == StIdle;
    assign bus.dictionary_recv_data    = data_q;
    assign bus.dictionary_recv_data_en = data_en_q;
    assign bus.reverse_byte_flag       = flag_q;
    assign bus.reverse_byte_num        = num_q;
    assign bus.reverse_byte_num_wren   = flag_q;
    assign bus.err_code                = err_q;
    assign bus.code_cnt                = code_cnt_q;
    assign bus.byte_cnt                = byte_cnt_q;
    assign bus.err_cnt                 = err_cnt_q;

endmodule
